rf_wr_arbiter: RTL and testbench
================================

# rf_wr_arbiter

Write-port controller for the 32x32 two-read/one-write register file (`rf_2r1w`). After reset it sequences a hardware clear of every entry. It then shares the single write port among `NREQ` requesters with round-robin arbitration and a valid/ready handshake. It drives `i_wr_en/i_wr_addr/i_wr_data` of the register file directly, and read ports are untouched.

## Interface
- `NREQ`, 4: number of write requesters (2..8)
- `DEPTH`, 32: register file entries; must equal 2**`ADDR_W`
- `ADDR_W`, 5: address width
- `DATA_W`, 32: data width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_req_valid`  in  NREQ  per-requester write request
- `i_req_addr`  in  NREQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- `i_req_data`  in  NREQ*DATA_W  packed data, same packing
- `o_req_ready`  out  NREQ  one-hot or zero; request i accepted when valid[i] & ready[i]
- `o_wr_en`  out  1  to RF `i_wr_en`
- `o_wr_addr`  out  ADDR_W  to RF `i_wr_addr`
- `o_wr_data`  out  DATA_W  to RF `i_wr_data`
- `o_grant_id`  out  $clog2(NREQ)  index of requester whose write is on `o_wr_*` (0 during clear)
- `o_init_done`  out  1  clear sequence finished

## Operation
- Two states: INIT, RUN. Reset forces INIT, clear counter `cnt`=0, round-robin pointer `ptr`=0.
- Reset values: `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_grant_id`=0, `o_init_done`=0, `o_req_ready`=0.
- INIT, every edge: `o_wr_en`<=1, `o_wr_addr`<=`cnt`, `o_wr_data`<=0, `cnt`<=`cnt`+1. At `cnt`==DEPTH-1: state<=RUN, `o_init_done`<=1.
- `o_req_ready` is 0 in INIT regardless of valids.
- RUN: grant = first i with `i_req_valid[i]`=1, searching `ptr`, `ptr`+1, … modulo NREQ. `o_req_ready[grant]`=1 (combinational from valid and `ptr`), others 0. If no valid, all ready=0.
- On acceptance: `o_wr_en`<=1, `o_wr_addr`/`o_wr_data`<=accepted request, `o_grant_id`<=grant, `ptr`<=(grant+1) mod NREQ.
- No acceptance in RUN: `o_wr_en`<=0; `o_wr_addr`, `o_wr_data` and `o_grant_id` hold; `ptr` holds.
- Requester must hold addr/data stable while valid and not ready; valid may not drop before acceptance.
- Writes to the same address in consecutive cycles are passed through in order; the last one wins in the RF.
- `rst` asserted mid-INIT or mid-RUN: outputs drop to reset values immediately. An in-flight registered write is discarded. The clear restarts from address 0.

## Timing
- Clear: DEPTH cycles. Write to addr k is presented in the cycle after edge k+1 post-reset. `o_init_done` rises together with addr DEPTH-1.
- First acceptance is possible in the cycle where `o_init_done`=1, which is the cycle address DEPTH-1 is presented. It does not conflict, because the accepted write appears one edge later.
- Request-to-RF latency: 1 cycle. Accept at edge N; `o_wr_*` valid in cycle N..N+1; RF write at edge N+1.
- Throughput: one write per cycle sustained. Each continuously valid requester is served within NREQ accepts (no starvation).
- `o_req_ready` has a combinational path from `i_req_valid`. Requesters must not derive valid from ready.

## Structure
- Shared package `rf_pkg`: `RF_DEPTH`=32, `RF_ADDR_W`=5, `RF_DATA_W`=32, state enum {INIT, RUN}. `rf_2r1w` and this block use the same constants.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req[N]`, `ptr`; outputs one-hot `gnt` and `gnt_id`. Purely combinational. `ptr` register stays in `rf_wr_arbiter`.
- Top: state/counter FSM, output registers, mux of packed request buses by `gnt_id`.

## Test plan
- Reset then clear: release `rst`, no valids. Expect `o_wr_en`=1 for exactly 32 cycles, addr 0..31, data 0, `o_init_done` rising with addr 31. Then reading every RF address returns 0.
- Single requester: after init, req 2 writes addr 5, data 0xDEADBEEF. Expect ready[2] the same cycle, `o_wr_en`/addr 5/data next cycle, `o_grant_id`=2. RF read port 1 at addr 5 then returns 0xDEADBEEF.
- Round-robin fairness: all 4 valid continuously, each addr=i, data=10*i. Expect grant order 0,1,2,3,0,1… with one write per cycle.
- Pointer skip/wrap: `ptr`=3 after granting 2, valid only on 1 and 2. Expect grant 1, then 2, then 1.
- Back-pressure hold: req 0 and 1 valid with req 0 granted. Expect req 1 stalled with data held, accepted next cycle, no write lost or duplicated.
- Reset mid-operation: assert `rst` at clear addr 10 and again during a RUN burst. Expect all outputs at 0 immediately and the clear restarting at addr 0 after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and state type for the 32x32 2R1W register file and its write-port controller.
// No logic here: constants and types only.
// Any change here resizes both rf_2r1w and rf_wr_arbiter together.
package rf_pkg;

    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // INIT clears every entry after reset; RUN serves requesters.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// Round-robin grant picker: the first asserted req at or after ptr, searched modulo N.
// Latency: purely combinational.
// Backpressure: none. gnt is one-hot, or zero when no req is asserted.
//
// Ports:
//   req_i    : N-bit request vector
//   ptr_i    : index the search starts from (highest priority)
//   gnt_o    : one-hot grant
//   gnt_id_o : index of the granted bit (0 when nothing is granted)
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            // Walk the ring starting at ptr, wrapping at N.
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = IDW'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/rf_wr_arbiter.sv
// Write-port controller for rf_2r1w. Clears all entries after reset, then round-robins NREQ writers onto the single write port.
// Latency: a write accepted at edge N is on o_wr_* for one cycle and is written into the RF at edge N+1. The clear takes DEPTH cycles.
// Backpressure: o_req_ready is one-hot, is combinational from i_req_valid and the pointer, and stays 0 while the clear runs.
//
// Ports:
//   clk, rst                 : clock; asynchronous active-high reset
//   i_req_valid/addr/data    : per-requester write requests, packed at [i*W +: W]
//   o_req_ready              : per-requester accept strobe
//   o_wr_en/addr/data        : registered write port, wired straight to the RF
//   o_grant_id               : requester that owns the write on o_wr_* (0 during the clear)
//   o_init_done              : the clear sequence has finished
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NREQ*DATA_W-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_req_ready,
    output logic                     o_wr_en,
    output logic [ADDR_W-1:0]        o_wr_addr,
    output logic [DATA_W-1:0]        o_wr_data,
    output logic [IDW-1:0]           o_grant_id,
    output logic                     o_init_done
);

    // DEPTH must equal 2**ADDR_W, so the clear counter wraps naturally.
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [IDW-1:0]    ID_LAST  = IDW'(NREQ - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic                init_done_q, init_done_d;

    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_id;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr (
        .req_i    (i_req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // Grants are offered only in RUN, so the clear can never be pre-empted.
    assign o_req_ready = (state_q == RUN) ? gnt : '0;
    assign accept      = (state_q == RUN) && (|gnt);

    assign sel_addr = i_req_addr[int'(gnt_id) * ADDR_W +: ADDR_W];
    assign sel_data = i_req_data[int'(gnt_id) * DATA_W +: DATA_W];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_id_d  = grant_id_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                // The last clear write and o_init_done go out together.
                // Acceptance can start in that same cycle because the accepted write lands one edge later.
                if (cnt_q == CNT_LAST) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = sel_addr;
                    wr_data_d  = sel_data;
                    grant_id_d = gnt_id;
                    ptr_d      = (gnt_id == ID_LAST) ? '0 : gnt_id + IDW'(1);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_id_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            grant_id_q  <= grant_id_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_grant_id  = grant_id_q;
    assign o_init_done = init_done_q;

endmodule : rf_wr_arbiter

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter.
// The acceptance sampler predicts ready and grant from a ring-search model and queues the expected RF write.
// The monitor pops that write when it falls due and checks it.
module tb_rf_wr_arbiter;
    import rf_pkg::*;

    localparam int N  = 4;
    localparam int AW = RF_ADDR_W;
    localparam int DW = RF_DATA_W;
    localparam int D  = RF_DEPTH;

    typedef struct {
        int              due;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [1:0]      id;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      i_req_valid = '0;
    logic [N*AW-1:0]   i_req_addr  = '0;
    logic [N*DW-1:0]   i_req_data  = '0;
    logic [N-1:0]      o_req_ready;
    logic              o_wr_en;
    logic [AW-1:0]     o_wr_addr;
    logic [DW-1:0]     o_wr_data;
    logic [1:0]        o_grant_id;
    logic              o_init_done;

    rf_wr_arbiter #(.NREQ(N), .DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_grant_id  (o_grant_id),
        .o_init_done (o_init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          q[$];
    int            mptr    = 0;
    int            run_cyc = 32'h3fff_ffff;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic [1:0]    last_id   = '0;
    bit [N-1:0]    acc_flag  = '0;
    bit [N-1:0]    mask      = '0;
    int            prob      = 0;
    bit            fixed     = 1'b0;
    logic [AW-1:0] fix_addr [N];
    logic [DW-1:0] fix_data [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Requesters: hold each request until the sampler sees it accepted, then optionally start another.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                i_req_valid = '0;
                acc_flag    = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (acc_flag[i]) begin
                        i_req_valid[i] = 1'b0;
                        acc_flag[i]    = 1'b0;
                    end
                    if (!i_req_valid[i] && mask[i] && ($urandom_range(99) < prob)) begin
                        i_req_valid[i] = 1'b1;
                        if (fixed) begin
                            i_req_addr[i*AW +: AW] = fix_addr[i];
                            i_req_data[i*DW +: DW] = fix_data[i];
                        end else begin
                            // A narrow address range makes back-to-back writes to one address likely.
                            i_req_addr[i*AW +: AW] = AW'($urandom_range(3));
                            i_req_data[i*DW +: DW] = $urandom;
                        end
                    end
                end
            end
        end
    end

    // Acceptance sampler: reference ring search from the model pointer.
    always @(negedge clk) begin : sampler
        int   g;
        int   idx;
        logic [N-1:0] exp_rdy;
        exp_t e;
        if (rst) begin
            check("ready_in_reset", 64'(o_req_ready), 64'd0);
        end else if (cyc < run_cyc) begin
            check("ready_in_init", 64'(o_req_ready), 64'd0);
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && i_req_valid[idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("ready", 64'(o_req_ready), 64'(exp_rdy));
            if (g >= 0) begin
                e.due  = cyc + 1;
                e.addr = i_req_addr[g*AW +: AW];
                e.data = i_req_data[g*DW +: DW];
                e.id   = 2'(g);
                q.push_back(e);
                mptr        = (g + 1) % N;
                acc_flag[g] = 1'b1;
            end
        end
    end

    // Write-port monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            check("outs_in_reset", 64'({o_wr_en, o_init_done, o_grant_id, o_wr_addr, o_wr_data}), 64'd0);
        end else begin
            check("init_done", 64'(o_init_done), 64'(cyc >= run_cyc));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("wr_en", 64'(o_wr_en), 64'd1);
                check("wr_addr_data_id", 64'({o_wr_addr, o_wr_data, o_grant_id}), 64'({e.addr, e.data, e.id}));
                last_addr = e.addr;
                last_data = e.data;
                last_id   = e.id;
            end else begin
                check("wr_en_idle", 64'(o_wr_en), 64'd0);
                check("idle_hold", 64'({o_wr_addr, o_wr_data, o_grant_id}), 64'({last_addr, last_data, last_id}));
            end
        end
    end

    // Deassert reset just after an edge and queue the expected clear writes (address k in the cycle after edge k+1).
    task automatic release_rst();
        @(posedge clk);
        #2;
        rst     = 1'b0;
        mptr    = 0;
        run_cyc = cyc + D;
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e.due  = cyc + 1 + k;
            e.addr = AW'(k);
            e.data = '0;
            e.id   = '0;
            q.push_back(e);
        end
    endtask

    // Assert reset now: outputs must fall without waiting for a clock edge, and pending writes are dropped.
    task automatic assert_rst();
        rst = 1'b1;
        q.delete();
        last_addr = '0;
        last_data = '0;
        last_id   = '0;
        run_cyc   = 32'h3fff_ffff;
        #1;
        check("async_reset_outs",
              64'({o_wr_en, o_init_done, o_grant_id, o_wr_addr, o_wr_data, o_req_ready}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            fix_addr[i] = AW'(i);
            fix_data[i] = DW'(10 * i);
        end
        #1;
        check("reset_outs", 64'({o_wr_en, o_init_done, o_grant_id, o_wr_addr, o_wr_data, o_req_ready}), 64'd0);
        repeat (3) @(posedge clk);

        // Clear with no requesters.
        release_rst();
        repeat (40) @(posedge clk);

        // A single request from requester 2.
        fixed       = 1'b1;
        fix_addr[2] = 5'd5;
        fix_data[2] = 32'hDEAD_BEEF;
        prob        = 100;
        mask        = 4'b0100;
        @(posedge clk);
        mask = '0;
        repeat (4) @(posedge clk);

        // Fairness: all requesters continuously valid, addr=i, data=10*i.
        fix_addr[2] = 5'd2;
        fix_data[2] = 32'd20;
        mask        = 4'b1111;
        repeat (20) @(posedge clk);
        mask = '0;
        repeat (6) @(posedge clk);

        // Pointer skip and wrap with only 1 and 2 valid, then back-pressure with 0 and 1.
        mask = 4'b0110;
        repeat (12) @(posedge clk);
        mask = 4'b0011;
        repeat (12) @(posedge clk);
        mask = '0;
        repeat (6) @(posedge clk);

        // Random traffic.
        fixed = 1'b0;
        for (int r = 0; r < 20; r++) begin
            mask = 4'($urandom_range(15));
            prob = $urandom_range(20, 100);
            repeat (15) @(posedge clk);
        end

        // Reset at clear address 10, with requesters already active during the clear.
        mask = '0;
        repeat (6) @(posedge clk);
        assert_rst();
        repeat (2) @(posedge clk);
        mask = 4'b1111;
        prob = 50;
        release_rst();
        repeat (11) @(posedge clk);
        #1;
        check("pre_reset_clear_addr", 64'({o_wr_en, o_wr_addr}), 64'({1'b1, 5'd10}));
        #1;
        assert_rst();
        repeat (3) @(posedge clk);
        release_rst();

        // Reset in the middle of a RUN burst.
        repeat (D + 10) @(posedge clk);
        #2;
        assert_rst();
        repeat (2) @(posedge clk);
        release_rst();
        repeat (D + 30) @(posedge clk);

        // Drain: every held request is accepted within NREQ cycles.
        mask = '0;
        repeat (12) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        check("no_pending_valid", 64'(i_req_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rf_wr_arbiter
